quad_count_ctrl: RTL
====================

# quad_count_ctrl

Position and velocity controller for one quadrature channel. It consumes the 4X pulse and direction outputs of the quadrature decoder and keeps a signed position count. It runs a programmable velocity measurement window and hands coherent position/velocity snapshots to the peripheral register block through a req/ack handshake. It sits between the decoder and the host-facing register file, one instance per encoder.

## Interface
Parameters:
- POS_W, 16: position counter width, two's complement.
- VEL_W, 12: velocity (edges per window) width, two's complement.
- PER_W, 24: window-length register width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enc_out  in  1  4X pulse from decoder; every toggle is one quarter-count.
- enc_dir  in  1  0 = forward (increment), 1 = reverse (decrement).
- en  in  1  counting/window enable.
- period  in  PER_W  window length in clk cycles; 0 or 1 treated as 2.
- clr_req  in  1  one-cycle pulse: zero position and restart window.
- snap_req  in  1  level request for snapshot; held until snap_ack.
- snap_ack  out  1  one-cycle pulse; snap_pos/snap_vel valid this cycle and after.
- snap_pos  out  POS_W  latched position.
- snap_vel  out  VEL_W  latched velocity of last completed window.
- vel_valid  out  1  high once at least one window has completed since reset/clear.
- ovf  out  1  sticky; set on position wrap (or saturation) or velocity clamp; cleared by clr_req.

## Operation
- Edge detect: enc_q registers enc_out. A count event is enc_out != enc_q while en=1. The event uses enc_dir sampled in the same cycle.
- FSM states:
  - IDLE: en=0, counters frozen, window timer held at 0. Goes to RUN when en=1.
  - RUN: pos ±1 per event; win_cnt ±1 per event; timer increments. When the timer reaches period-1, goes to LATCH. When en=0, goes to IDLE.
  - LATCH: one cycle. vel ← win_cnt (including any event in this cycle), win_cnt ← 0, timer ← 0, vel_valid ← 1. Returns to RUN, or to IDLE if en=0.
  - CLEAR: one cycle, entered from any state on clr_req. pos, win_cnt, timer, vel and ovf are zeroed; vel_valid ← 0. Goes to RUN if en=1, else IDLE. An event coinciding with clr_req is discarded.
- clr_req has priority over LATCH and snapshot.
- Velocity clamp: if |win_cnt| would exceed the VEL_W signed range, it holds at max/min and ovf is set.
- Position: wraps modulo 2^POS_W and ovf is set on wrap. Under the configuration macro it saturates instead (see Configuration).
- Snapshot: with snap_req high and no ack pending, the next cycle copies pos and vel into snap_pos/snap_vel and pulses snap_ack.
  - snap_pos includes the event counted in the request cycle.
  - If LATCH coincides with the copy, snap_vel takes the new vel.
  - Only one ack per request: snap_req must drop for at least one cycle before another ack is issued.
  - During a CLEAR cycle, the ack is deferred one cycle and reports zeros.

## Timing
- Reset values: snap_ack 0, snap_pos 0, snap_vel 0, vel_valid 0, ovf 0, FSM IDLE, enc_q 0, internal pos/win_cnt/timer/vel 0.
- Event latency: enc_out toggle at cycle n is registered in pos at the end of cycle n+1.
- Window: exactly period cycles RUN→RUN, including the LATCH cycle.
- snap_ack latency: 1 cycle after the first snap_req-high cycle, 2 if deferred by CLEAR.
- Reset mid-window or mid-handshake abandons all state; no ack is issued for a pending request.

## Configuration
- QUAD_COUNT_CTRL_SAT_EN:
  - Defined: position saturates at +2^(POS_W-1)-1 / -2^(POS_W-1), stays there until a reverse event or clr_req, and sets ovf.
  - Undefined: position wraps modulo 2^POS_W and sets ovf on wrap.
- Velocity clamping is unconditional.

## Structure
- Shared package quad_pkg: FSM state encoding (IDLE, RUN, LATCH, CLEAR), direction constant FWD=0, and the default widths.
- One sub-module: quad_sat_acc. A signed ±1 accumulator with clear, saturate/wrap select and overflow flag. It is instanced for pos (mode per macro) and win_cnt (saturate).

## Test plan
- period=10, en=1, 7 forward toggles in the first window: vel=7 at the LATCH cycle, vel_valid rises, pos=7.
- 3 reverse toggles from pos=0, then snap_req: snap_pos=-3 (0xFFFD), snap_ack one cycle later.
- POS_W=4, pos=7, one forward event: without the macro pos=-8 and ovf=1; with QUAD_COUNT_CTRL_SAT_EN pos=7 and ovf=1.
- clr_req in the same cycle as an event and a window end: pos=0, vel=0, vel_valid=0, ovf=0, window restarts with a full period.
- snap_req held 5 cycles: exactly one snap_ack. Drop it one cycle, raise again: second ack.
- VEL_W=4, 10 forward events in one window: snap_vel=7, ovf=1.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and defaults for the quadrature position/velocity controller.
package quad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LATCH = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam logic FWD = 1'b0;

  localparam int DEF_POS_W = 16;
  localparam int DEF_VEL_W = 12;
  localparam int DEF_PER_W = 24;

endpackage

// File: rtl/quad_sat_acc.sv
// Signed +/-1 accumulator with clear; SAT selects saturate (1) or wrap (0) at the range limits.
module quad_sat_acc
  import quad_pkg::*;
#(
  parameter int W   = 16,
  parameter bit SAT = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                inc,
  input  logic                dir,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic signed [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic signed [W-1:0] value;

  // sum is the count with this cycle's event applied, before any clear.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    sum = value;
    ovf = 1'b0;
    if (inc) begin
      if (dir == FWD) begin
        if (value == MAX) begin
          ovf = 1'b1;
          sum = SAT ? MAX : MIN;
        end else begin
          sum = value + ONE;
        end
      end else begin
        if (value == MIN) begin
          ovf = 1'b1;
          sum = SAT ? MIN : MAX;
        end else begin
          sum = value - ONE;
        end
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset || clr) value <= '0;
    else              value <= sum;
  end

endmodule

// File: rtl/quad_count_ctrl.sv
// Quadrature position counter with windowed velocity and req/ack snapshots.
// Define QUAD_COUNT_CTRL_SAT_EN to saturate the position instead of wrapping it.
module quad_count_ctrl
  import quad_pkg::*;
#(
  parameter int POS_W = DEF_POS_W,
  parameter int VEL_W = DEF_VEL_W,
  parameter int PER_W = DEF_PER_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enc_out,
  input  logic                    enc_dir,
  input  logic                    en,
  input  logic [PER_W-1:0]        period,
  input  logic                    clr_req,
  input  logic                    snap_req,
  output logic                    snap_ack,
  output logic signed [POS_W-1:0] snap_pos,
  output logic signed [VEL_W-1:0] snap_vel,
  output logic                    vel_valid,
  output logic                    ovf
);

`ifdef QUAD_COUNT_CTRL_SAT_EN
  localparam bit POS_SAT = 1'b1;
`else
  localparam bit POS_SAT = 1'b0;
`endif

  state_t                  state, state_next;
  logic                    enc_q;
  logic [PER_W-1:0]        timer, timer_next, per_m2;
  logic                    clr_zero, latch, ev, take, snap_done;
  logic signed [POS_W-1:0] pos_sum;
  logic signed [VEL_W-1:0] win_sum, vel, vel_next;
  logic                    pos_ovf, win_ovf;

  // A clr_req cycle and the CLEAR cycle after it both force everything to zero.
  assign clr_zero = clr_req || (state == ST_CLEAR);
  assign latch    = (state == ST_LATCH) && !clr_zero;
  assign ev       = en && (enc_out != enc_q) && !clr_zero;
  assign per_m2   = (period < PER_W'(2)) ? '0 : period - PER_W'(2);
  assign take     = snap_req && !snap_done && !clr_req;

  quad_sat_acc #(.W(POS_W), .SAT(POS_SAT)) u_pos (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_zero),
    .inc   (ev),
    .dir   (enc_dir),
    .sum   (pos_sum),
    .ovf   (pos_ovf)
  );

  quad_sat_acc #(.W(VEL_W), .SAT(1'b1)) u_win (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_zero || latch),
    .inc   (ev),
    .dir   (enc_dir),
    .sum   (win_sum),
    .ovf   (win_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clr_req) begin
      state_next = ST_CLEAR;
    end else begin
      case (state)
        ST_IDLE:  if (en) state_next = ST_RUN;
        ST_RUN: begin
          if (!en)                  state_next = ST_IDLE;
          else if (timer >= per_m2) state_next = ST_LATCH;
        end
        ST_LATCH, ST_CLEAR: state_next = en ? ST_RUN : ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // RUN spends period-1 cycles counting; LATCH is the last cycle of the window.
  always_comb begin
    timer_next = '0;
    vel_next   = vel;
    if (clr_zero) begin
      vel_next = '0;
    end else begin
      if (state == ST_RUN && en) timer_next = timer + PER_W'(1);
      if (latch)                 vel_next   = win_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_q     <= 1'b0;
      timer     <= '0;
      vel       <= '0;
      vel_valid <= 1'b0;
      ovf       <= 1'b0;
      snap_ack  <= 1'b0;
      snap_pos  <= '0;
      snap_vel  <= '0;
      snap_done <= 1'b0;
    end else begin
      enc_q <= enc_out;
      timer <= timer_next;
      vel   <= vel_next;
      if (clr_zero) begin
        vel_valid <= 1'b0;
        ovf       <= 1'b0;
      end else begin
        if (latch)              vel_valid <= 1'b1;
        if (pos_ovf || win_ovf) ovf       <= 1'b1;
      end
      snap_ack <= take;
      if (take) begin
        snap_pos <= pos_sum;
        snap_vel <= vel_next;
      end
      // One ack per request: re-armed only after snap_req drops.
      snap_done <= snap_req && (snap_done || take);
    end
  end

endmodule
